// File: rtl/rsa_modexp_enc_if.sv
// Request/response bundle for the RSA encryptor: operands and start in, status and ciphertext out.
interface rsa_modexp_enc_if #(
  parameter int W = 14
);
  logic         start;
  logic [W-1:0] m;
  logic [W-1:0] e;
  logic [W-1:0] n;
  logic         busy;
  logic         done;
  logic [W-1:0] c;
  logic         err;

  modport master (output start, m, e, n, input busy, done, c, err);
  modport slave  (input start, m, e, n, output busy, done, c, err);
endinterface

// File: rtl/rsa_modexp_enc.sv
// Sequential RSA encryptor c = m^e mod n: left-to-right square-and-multiply built on
// bit-serial shift-add modular multiplication, fixed latency of 2*W*W+1 edges.
module rsa_modexp_enc #(
  parameter int W = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  rsa_modexp_enc_if.slave     bus
);

  localparam int KW = $clog2(W);
  localparam logic [KW-1:0] LAST_IDX = KW'(W - 1);

  typedef enum logic [2:0] {IDLE, SQR, MUL, FIN, ERR} state_t;

  state_t        state_q;
  logic [KW-1:0] i_q;
  logic [KW-1:0] k_q;
  logic [W-1:0]  m_q, e_q, n_q;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  p_q;
  logic [W-1:0]  p_d;
  logic [W-1:0]  mul_b;
  logic          busy_q, done_q, err_q;
  logic [W-1:0]  c_q;

  // One interleaved step: p = 2p mod n, then optionally p = p + a mod n (W+1 bit headroom).
  function automatic logic [W-1:0] mm_step(input logic [W-1:0] p, input logic [W-1:0] a,
                                           input logic [W-1:0] n, input logic add);
    logic [W:0] t;
    t = {p, 1'b0};
    if (t >= {1'b0, n}) t = t - {1'b0, n};
    if (add) begin
      t = t + {1'b0, a};
      if (t >= {1'b0, n}) t = t - {1'b0, n};
    end
    return t[W-1:0];
  endfunction

  always_comb begin
    mul_b = (state_q == SQR) ? acc_q : m_q;
    p_d   = mm_step(p_q, acc_q, n_q, mul_b[i_q]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      c_q     <= '0;
      i_q     <= '0;
      k_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            m_q    <= bus.m;
            e_q    <= bus.e;
            n_q    <= bus.n;
            acc_q  <= W'(1);
            p_q    <= '0;
            i_q    <= LAST_IDX;
            k_q    <= LAST_IDX;
            busy_q <= 1'b1;
            state_q <= (bus.n < W'(2) || bus.m >= bus.n) ? ERR : SQR;
          end
        end
        SQR: begin
          if (i_q == '0) begin
            acc_q   <= p_d;
            p_q     <= '0;
            i_q     <= LAST_IDX;
            state_q <= MUL;
          end else begin
            p_q <= p_d;
            i_q <= i_q - 1'b1;
          end
        end
        MUL: begin
          if (i_q == '0) begin
            // The multiply always runs; only the exponent bit decides whether it is kept.
            if (e_q[k_q]) acc_q <= p_d;
            p_q <= '0;
            i_q <= LAST_IDX;
            if (k_q == '0) begin
              state_q <= FIN;
            end else begin
              k_q     <= k_q - 1'b1;
              state_q <= SQR;
            end
          end else begin
            p_q <= p_d;
            i_q <= i_q - 1'b1;
          end
        end
        FIN: begin
          c_q     <= acc_q;
          err_q   <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        ERR: begin
          c_q     <= '0;
          err_q   <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.c    = c_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_rsa_modexp_enc.sv
// Bench for rsa_modexp_enc: cycle-level reference model plus directed vectors with literal results.
module tb_rsa_modexp_enc;
  localparam int W = 14;
  localparam int LAT = 2 * W * W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  rsa_modexp_enc_if #(.W(W)) bus ();
  rsa_modexp_enc #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Plain repeated multiplication, independent of any square-and-multiply ordering.
  function automatic logic [W-1:0] ref_pow(input int mm, input int ee, input int nn);
    longint r;
    r = 1 % nn;
    for (int j = 0; j < ee; j++) r = (r * mm) % nn;
    return W'(r);
  endfunction

  // Cycle model: what busy/done/c/err must be after each rising edge.
  logic         mbusy = 1'b0, mdone = 1'b0, merr = 1'b0, pe = 1'b0;
  logic [W-1:0] mc = '0, pc = '0;
  int           rem = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbusy <= 1'b0; mdone <= 1'b0; mc <= '0; merr <= 1'b0; rem <= 0;
    end else begin
      mdone <= 1'b0;
      if (mbusy) begin
        if (rem == 1) begin
          mbusy <= 1'b0; mdone <= 1'b1; mc <= pc; merr <= pe;
        end
        rem <= rem - 1;
      end else if (bus.start) begin
        if (bus.n < 2 || bus.m >= bus.n) begin
          pe <= 1'b1; pc <= '0; rem <= 1;
        end else begin
          pe <= 1'b0; pc <= ref_pow(int'(bus.m), int'(bus.e), int'(bus.n)); rem <= LAT;
        end
        mbusy <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one request from a negedge and follow it to done; optional second start mid-operation.
  task automatic do_op(input logic [W-1:0] mm, input logic [W-1:0] ee, input logic [W-1:0] nn,
                       input int gap, input int inj, input logic [W-1:0] expc,
                       input logic experr, input int explat, output logic [W-1:0] cres);
    int cnt;
    int bcnt;
    repeat (gap) @(negedge clk);
    bus.m = mm; bus.e = ee; bus.n = nn; bus.start = 1'b1;
    cnt = 0; bcnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (bus.busy) bcnt++;
      if (inj != 0 && cnt == inj) begin
        bus.start = 1'b1; bus.m = 14'd5; bus.e = 14'd7;
      end else begin
        bus.start = 1'b0;
      end
    end while (bus.done !== 1'b1 && cnt < 1000);
    cres = bus.c;
    if (cnt >= 1000) chk("done_timeout", 32'(cnt), 32'(explat + 1));
    chk("c", 32'(bus.c), 32'(expc));
    chk("err", 32'(bus.err), 32'(experr));
    chk("latency", 32'(cnt - 1), 32'(explat));
    chk("busy_cycles", 32'(bcnt), 32'(explat));
  endtask

  logic [W-1:0] cr, c1;
  logic [W-1:0] rt_m [4] = '{14'd1, 14'd65, 14'd4242, 14'd10572};

  initial begin
    bus.start = 1'b0; bus.m = '0; bus.e = '0; bus.n = '0;
    fork
      forever begin
        @(negedge clk);
        chk("cyc_busy", 32'(bus.busy), 32'(mbusy));
        chk("cyc_done", 32'(bus.done), 32'(mdone));
        chk("cyc_c", 32'(bus.c), 32'(mc));
        chk("cyc_err", 32'(bus.err), 32'(merr));
      end
    join_none

    chk("model_100_3", 32'(ref_pow(100, 3, 10573)), 32'd6138);
    chk("model_rt", 32'(ref_pow(int'(ref_pow(4242, 89, 10573)), 233, 10573)), 32'd4242);

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_c", 32'(bus.c), 32'd0);
    rst_n = 1'b1;

    do_op(14'd100, 14'd3, 14'd10573, 2, 0, 14'd6138, 1'b0, LAT, cr);
    do_op(14'd2, 14'd10, 14'd10573, 1, 0, 14'd1024, 1'b0, LAT, cr);
    do_op(14'd100, 14'd2, 14'd10573, 1, 0, 14'd10000, 1'b0, LAT, cr);
    do_op(14'd55, 14'd0, 14'd10573, 1, 0, 14'd1, 1'b0, LAT, cr);
    do_op(14'd0, 14'd89, 14'd10573, 1, 0, 14'd0, 1'b0, LAT, cr);
    do_op(14'd0, 14'd0, 14'd10573, 1, 0, 14'd1, 1'b0, LAT, cr);

    for (int r = 0; r < 4; r++) begin
      do_op(rt_m[r], 14'd89, 14'd10573, 1, 0, ref_pow(int'(rt_m[r]), 89, 10573), 1'b0, LAT, c1);
      do_op(c1, 14'd233, 14'd10573, 1, 0, rt_m[r], 1'b0, LAT, cr);
    end

    do_op(14'd10573, 14'd89, 14'd10573, 1, 0, 14'd0, 1'b1, 1, cr);
    do_op(14'd5, 14'd3, 14'd1, 1, 0, 14'd0, 1'b1, 1, cr);

    // Second start mid-operation must be ignored.
    do_op(14'd100, 14'd3, 14'd10573, 1, 50, 14'd6138, 1'b0, LAT, cr);
    // Back-to-back: issued in the done cycle of the previous request.
    do_op(14'd2, 14'd10, 14'd10573, 0, 0, 14'd1024, 1'b0, LAT, cr);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    bus.m = 14'd100; bus.e = 14'd3; bus.n = 14'd10573; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (200) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_c", 32'(bus.c), 32'd0);
    chk("arst_err", 32'(bus.err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_op(14'd100, 14'd2, 14'd10573, 2, 0, 14'd10000, 1'b0, LAT, cr);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
